// File: rtl/logic_unit_pkg.sv
// Shared types for the sliced bitwise logic unit.
package logic_unit_pkg;

    localparam int unsigned OP_W = 3;

    // Run-time selectable logic operations.
    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOR   = 3'b011,
        OP_NAND  = 3'b100,
        OP_XNOR  = 3'b101,
        OP_ANDN  = 3'b110,
        OP_PASSA = 3'b111
    } op_e;

    // Control FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// Slice-wide combinational logic cell, time-multiplexed across operand slices.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int unsigned SLICE = 4
) (
    input  op_e              op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    // Select one of the eight bitwise functions.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOR:   y = ~(a | b);
            OP_NAND:  y = ~(a & b);
            OP_XNOR:  y = ~(a ^ b);
            OP_ANDN:  y = a & ~b;
            OP_PASSA: y = a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/sliced_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-bit slice per clock, start/busy/done handshake.
module sliced_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    localparam int unsigned NUM_SLICES = (SLICE > 0) ? (WIDTH / SLICE) : 1;
    localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    // Reject geometries that cannot be sliced evenly.
    generate
        if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_geometry
            $error("sliced_logic_unit: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    state_e           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [WIDTH-1:0] a_l, a_l_nxt;
    logic [WIDTH-1:0] b_l, b_l_nxt;
    op_e              op_l, op_l_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic             zero_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [31:0]      base;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] r_slice;

    // Bit offset of the slice currently being processed.
    assign base    = 32'(idx) * 32'(SLICE);
    assign a_slice = a_l[base +: SLICE];
    assign b_slice = b_l[base +: SLICE];

    logic_slice #(
        .SLICE (SLICE)
    ) u_logic_slice (
        .op (op_l),
        .a  (a_slice),
        .b  (b_slice),
        .y  (r_slice)
    );

    // State and datapath registers; reset returns every output to its idle value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            a_l   <= '0;
            b_l   <= '0;
            op_l  <= OP_AND;
            acc   <= '0;
            y     <= '0;
            zero  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            a_l   <= a_l_nxt;
            b_l   <= b_l_nxt;
            op_l  <= op_l_nxt;
            acc   <= acc_nxt;
            y     <= y_nxt;
            zero  <= zero_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state and next-register values; done is a single-cycle pulse.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        a_l_nxt   = a_l;
        b_l_nxt   = b_l;
        op_l_nxt  = op_l;
        acc_nxt   = acc;
        y_nxt     = y;
        zero_nxt  = zero;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    a_l_nxt   = a;
                    b_l_nxt   = b;
                    op_l_nxt  = op_e'(op);
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_nxt[base +: SLICE] = r_slice;
                idx_nxt = idx + IDX_W'(1);
                if (idx == LAST_IDX) begin
                    // Publish the complete accumulator, last slice included.
                    y_nxt     = acc_nxt;
                    zero_nxt  = (acc_nxt == '0);
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    idx_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sliced_logic_unit.sv
// Directed self-checking bench for sliced_logic_unit at three geometries.
module tb_sliced_logic_unit;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, zero;
    logic [31:0] y;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, zero8;
    logic [7:0]  y8;

    logic        start12;
    logic [2:0]  op12;
    logic [11:0] a12, b12;
    logic        busy12, done12, zero12;
    logic [11:0] y12;

    int tests_run    = 0;
    int tests_failed = 0;

    sliced_logic_unit #(.WIDTH(32), .SLICE(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .zero(zero)
    );

    sliced_logic_unit #(.WIDTH(8), .SLICE(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .y(y8), .zero(zero8)
    );

    sliced_logic_unit #(.WIDTH(12), .SLICE(4)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .op(op12), .a(a12), .b(b12),
        .busy(busy12), .done(done12), .y(y12), .zero(zero12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the 32-bit instance and check latency, busy span and result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] exp_y, input logic exp_z);
        int n;
        int busy_cnt;
        op = o; a = aa; b = bb; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_y"}, y, exp_y);
        check({tag, "_zero"}, 32'(zero), 32'(exp_z));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] y_before;

        rst_n = 1'b0;
        start = 1'b0; op = 3'b000; a = '0; b = '0;
        start8 = 1'b0; op8 = 3'b000; a8 = '0; b8 = '0;
        start12 = 1'b0; op12 = 3'b000; a12 = '0; b12 = '0;

        // 1. Reset with random activity on the inputs.
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); a = $urandom; b = $urandom; op = 3'($urandom);
            tick();
        end
        check("rst_y", y, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_y", y, 32'h0);
        check("idle_zero", 32'(zero), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);

        // 2. NOR with default geometry; done must clear after one cycle.
        run_op("nor", 3'b011, 32'h0000FFFF, 32'h00FF00FF, 32'hFF000000, 1'b0);
        tick();
        check("nor_done_pulse", 32'(done), 32'd0);
        check("nor_y_held", y, 32'hFF000000);

        // 3. Zero result, then MSB slice.
        run_op("xor", 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1);
        tick();
        run_op("or_msb", 3'b001, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0);
        tick();

        // 4. Start during busy is ignored; y never shows partial accumulator.
        op = 3'b000; a = 32'hF0F0F0F0; b = 32'hFFFF0000; start = 1'b1;
        tick();
        start = 1'b0;
        y_before = y;
        tick(); tick();
        op = 3'b001; a = 32'h12345678; b = 32'h0F0F0F0F; start = 1'b1;
        tick();
        start = 1'b0;
        check("hs_y_stable_midop", y, y_before);
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check("hs_ignored_latency", 32'(n), 32'd5);
        check("hs_ignored_y", y, 32'hF0F00000);
        // Start in the done cycle is accepted.
        run_op("andn_b2b", 3'b110, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0);
        tick();

        // 5. Reset in the middle of an operation.
        op = 3'b100; a = 32'h0F0F0F0F; b = 32'h00FF00FF; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_y", y, 32'h0);
        check("midrst_zero", 32'(zero), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) n++;
        end
        check("midrst_no_done", 32'(n), 32'd0);
        rst_n = 1'b1;
        tick();
        run_op("passa", 3'b111, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        tick();

        // 6a. Single-slice geometry: done one cycle after the start edge.
        op8 = 3'b110; a8 = 8'hF0; b8 = 8'h3C; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin tick(); n++; end
        check("w8_latency", 32'(n), 32'd1);
        check("w8_y", 32'(y8), 32'h000000C0);
        check("w8_zero", 32'(zero8), 32'd0);
        tick();
        check("w8_done_pulse", 32'(done8), 32'd0);

        // 6b. Three-slice geometry with non-power-of-two slice count.
        op12 = 3'b101; a12 = 12'hABC; b12 = 12'hABC; start12 = 1'b1;
        tick();
        start12 = 1'b0;
        n = 0;
        while (!done12 && n < 20) begin tick(); n++; end
        check("w12_latency", 32'(n), 32'd3);
        check("w12_y", 32'(y12), 32'h00000FFF);
        check("w12_zero", 32'(zero12), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
